// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and FSM state encodings for the peripheral interconnect.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FWD,
    W_RESP,
    W_ERR
  } w_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_FWD,
    R_WAIT,
    R_RESP,
    R_ERR
  } r_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Base/mask address decoder: one-hot select of the lowest-index matching subordinate.
module axil_addr_decode #(
  parameter int unsigned N_SUB      = 3,
  parameter int unsigned AXI_AWIDTH = 32
) (
  input  logic [AXI_AWIDTH-1:0]       addr,
  input  logic [N_SUB*AXI_AWIDTH-1:0] sub_base,
  input  logic [N_SUB*AXI_AWIDTH-1:0] sub_mask,
  output logic [N_SUB-1:0]            sel,
  output logic                        hit
);

  // Scan upward so the first hit shadows any higher-index overlap
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < N_SUB; i++) begin
      if (!hit && ((addr & sub_mask[i*AXI_AWIDTH +: AXI_AWIDTH]) ==
                   sub_base[i*AXI_AWIDTH +: AXI_AWIDTH])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_periph_interconnect.sv
// AXI4-Lite 1-to-N interconnect: independent single-outstanding read and write paths.
module axil_periph_interconnect
  import axil_pkg::*;
#(
  parameter int unsigned N_SUB      = 3,
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32,
  parameter logic [N_SUB*AXI_AWIDTH-1:0] SUB_BASE = {32'h0000_8000, 32'h0000_4000, 32'h0000_0000},
  parameter logic [N_SUB*AXI_AWIDTH-1:0] SUB_MASK = {32'h0000_F000, 32'h0000_C000, 32'h0000_C000},
  localparam int unsigned STRB_W    = AXI_DWIDTH / 8
) (
  input  logic                         AXI_ACLK,
  input  logic                         AXI_ARESETN,
  // host write
  input  logic [AXI_AWIDTH-1:0]        HOST_AXI_AWADDR,
  input  logic                         HOST_AXI_AWVALID,
  output logic                         HOST_AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]        HOST_AXI_WDATA,
  input  logic [STRB_W-1:0]            HOST_AXI_WSTRB,
  input  logic                         HOST_AXI_WVALID,
  output logic                         HOST_AXI_WREADY,
  output logic [1:0]                   HOST_AXI_BRESP,
  output logic                         HOST_AXI_BVALID,
  input  logic                         HOST_AXI_BREADY,
  // host read
  input  logic [AXI_AWIDTH-1:0]        HOST_AXI_ARADDR,
  input  logic                         HOST_AXI_ARVALID,
  output logic                         HOST_AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]        HOST_AXI_RDATA,
  output logic [1:0]                   HOST_AXI_RRESP,
  output logic                         HOST_AXI_RVALID,
  input  logic                         HOST_AXI_RREADY,
  // subordinate write
  output logic [N_SUB*AXI_AWIDTH-1:0]  SUB_AXI_AWADDR,
  output logic [N_SUB-1:0]             SUB_AXI_AWVALID,
  input  logic [N_SUB-1:0]             SUB_AXI_AWREADY,
  output logic [N_SUB*AXI_DWIDTH-1:0]  SUB_AXI_WDATA,
  output logic [N_SUB*STRB_W-1:0]      SUB_AXI_WSTRB,
  output logic [N_SUB-1:0]             SUB_AXI_WVALID,
  input  logic [N_SUB-1:0]             SUB_AXI_WREADY,
  input  logic [N_SUB*2-1:0]           SUB_AXI_BRESP,
  input  logic [N_SUB-1:0]             SUB_AXI_BVALID,
  output logic [N_SUB-1:0]             SUB_AXI_BREADY,
  // subordinate read
  output logic [N_SUB*AXI_AWIDTH-1:0]  SUB_AXI_ARADDR,
  output logic [N_SUB-1:0]             SUB_AXI_ARVALID,
  input  logic [N_SUB-1:0]             SUB_AXI_ARREADY,
  input  logic [N_SUB*AXI_DWIDTH-1:0]  SUB_AXI_RDATA,
  input  logic [N_SUB*2-1:0]           SUB_AXI_RRESP,
  input  logic [N_SUB-1:0]             SUB_AXI_RVALID,
  output logic [N_SUB-1:0]             SUB_AXI_RREADY
);

  w_state_t                w_state;
  r_state_t                r_state;

  logic                    aw_got, w_got;
  logic [AXI_AWIDTH-1:0]   awaddr_q;
  logic [AXI_DWIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    awready_q, wready_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic [N_SUB-1:0]        w_sel_q, sub_awvalid_q, sub_wvalid_q, sub_bready_q;

  logic [AXI_AWIDTH-1:0]   araddr_q;
  logic                    arready_q, rvalid_q;
  logic [AXI_DWIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic [N_SUB-1:0]        r_sel_q, sub_arvalid_q, sub_rready_q;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    sub_aw_hs, sub_w_hs, sub_b_hs, sub_ar_hs, sub_r_hs;
  logic                    aw_done, w_done;
  logic [AXI_AWIDTH-1:0]   aw_dec_addr;
  logic [N_SUB-1:0]        aw_sel, ar_sel;
  logic                    aw_hit, ar_hit;
  logic [1:0]              b_resp_mux, r_resp_mux;
  logic [AXI_DWIDTH-1:0]   r_data_mux;

  assign aw_hs     = HOST_AXI_AWVALID & awready_q;
  assign w_hs      = HOST_AXI_WVALID & wready_q;
  assign ar_hs     = HOST_AXI_ARVALID & arready_q;
  assign sub_aw_hs = |(sub_awvalid_q & SUB_AXI_AWREADY);
  assign sub_w_hs  = |(sub_wvalid_q & SUB_AXI_WREADY);
  assign sub_b_hs  = |(sub_bready_q & SUB_AXI_BVALID);
  assign sub_ar_hs = |(sub_arvalid_q & SUB_AXI_ARREADY);
  assign sub_r_hs  = |(sub_rready_q & SUB_AXI_RVALID);
  assign aw_done   = ~(|sub_awvalid_q) | sub_aw_hs;
  assign w_done    = ~(|sub_wvalid_q) | sub_w_hs;

  // AW may arrive on the same edge that completes the pair, so decode the live address then
  assign aw_dec_addr = aw_got ? awaddr_q : HOST_AXI_AWADDR;

  axil_addr_decode #(.N_SUB(N_SUB), .AXI_AWIDTH(AXI_AWIDTH)) u_aw_decode (
    .addr(aw_dec_addr), .sub_base(SUB_BASE), .sub_mask(SUB_MASK), .sel(aw_sel), .hit(aw_hit)
  );

  axil_addr_decode #(.N_SUB(N_SUB), .AXI_AWIDTH(AXI_AWIDTH)) u_ar_decode (
    .addr(HOST_AXI_ARADDR), .sub_base(SUB_BASE), .sub_mask(SUB_MASK), .sel(ar_sel), .hit(ar_hit)
  );

  // Response mux from the latched one-hot selects
  always_comb begin
    b_resp_mux = '0;
    r_resp_mux = '0;
    r_data_mux = '0;
    for (int i = 0; i < N_SUB; i++) begin
      if (w_sel_q[i]) b_resp_mux = SUB_AXI_BRESP[2*i +: 2];
      if (r_sel_q[i]) begin
        r_resp_mux = SUB_AXI_RRESP[2*i +: 2];
        r_data_mux = SUB_AXI_RDATA[i*AXI_DWIDTH +: AXI_DWIDTH];
      end
    end
  end

  // Write path FSM with registered outputs
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      w_state       <= W_IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= '0;
      w_sel_q       <= '0;
      sub_awvalid_q <= '0;
      sub_wvalid_q  <= '0;
      sub_bready_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q <= HOST_AXI_AWADDR;
            aw_got   <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= HOST_AXI_WDATA;
            wstrb_q <= HOST_AXI_WSTRB;
            w_got   <= 1'b1;
          end
          awready_q <= ~(aw_got | aw_hs);
          wready_q  <= ~(w_got | w_hs);
          if ((aw_got | aw_hs) && (w_got | w_hs)) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            if (aw_hit) begin
              w_sel_q       <= aw_sel;
              sub_awvalid_q <= aw_sel;
              sub_wvalid_q  <= aw_sel;
              w_state       <= W_FWD;
            end else begin
              bvalid_q <= 1'b1;
              bresp_q  <= RESP_DECERR;
              w_state  <= W_ERR;
            end
          end
        end
        W_FWD: begin
          if (sub_aw_hs) sub_awvalid_q <= '0;
          if (sub_w_hs)  sub_wvalid_q  <= '0;
          if (~(|sub_bready_q) && aw_done && w_done) sub_bready_q <= w_sel_q;
          if (sub_b_hs) begin
            sub_bready_q <= '0;
            bresp_q      <= b_resp_mux;
            bvalid_q     <= 1'b1;
            w_state      <= W_RESP;
          end
        end
        W_RESP, W_ERR: begin
          if (HOST_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path FSM with registered outputs
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_state       <= R_IDLE;
      araddr_q      <= '0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= '0;
      r_sel_q       <= '0;
      sub_arvalid_q <= '0;
      sub_rready_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= ~ar_hs;
          if (ar_hs) begin
            araddr_q <= HOST_AXI_ARADDR;
            if (ar_hit) begin
              r_sel_q       <= ar_sel;
              sub_arvalid_q <= ar_sel;
              r_state       <= R_FWD;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
              rresp_q  <= RESP_DECERR;
              r_state  <= R_ERR;
            end
          end
        end
        R_FWD: begin
          if (sub_ar_hs) begin
            sub_arvalid_q <= '0;
            sub_rready_q  <= r_sel_q;
            r_state       <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (sub_r_hs) begin
            sub_rready_q <= '0;
            rdata_q      <= r_data_mux;
            rresp_q      <= r_resp_mux;
            rvalid_q     <= 1'b1;
            r_state      <= R_RESP;
          end
        end
        R_RESP, R_ERR: begin
          if (HOST_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign HOST_AXI_AWREADY = awready_q;
  assign HOST_AXI_WREADY  = wready_q;
  assign HOST_AXI_BVALID  = bvalid_q;
  assign HOST_AXI_BRESP   = bresp_q;
  assign HOST_AXI_ARREADY = arready_q;
  assign HOST_AXI_RVALID  = rvalid_q;
  assign HOST_AXI_RDATA   = rdata_q;
  assign HOST_AXI_RRESP   = rresp_q;

  // Payloads are broadcast; only the selected slice ever sees a valid
  assign SUB_AXI_AWADDR  = {N_SUB{awaddr_q}};
  assign SUB_AXI_WDATA   = {N_SUB{wdata_q}};
  assign SUB_AXI_WSTRB   = {N_SUB{wstrb_q}};
  assign SUB_AXI_ARADDR  = {N_SUB{araddr_q}};
  assign SUB_AXI_AWVALID = sub_awvalid_q;
  assign SUB_AXI_WVALID  = sub_wvalid_q;
  assign SUB_AXI_BREADY  = sub_bready_q;
  assign SUB_AXI_ARVALID = sub_arvalid_q;
  assign SUB_AXI_RREADY  = sub_rready_q;

endmodule

// File: doc/axil_periph_interconnect.md
# axil_periph_interconnect

Parametrised AXI4-Lite 1-to-N interconnect placed between the core's host data port and the data-side subordinates: data memory, UART and future peripherals. It decodes each address against a per-subordinate base/mask pair and routes the transaction to exactly one subordinate. Unmapped addresses get a DECERR response. Read and write channels run independently, each with one outstanding transaction, and every response is registered.

## Interface
- N_SUB, 3: number of subordinate ports (1..8)
- AXI_AWIDTH, 32: address width
- AXI_DWIDTH, 32: data width (32 or 64); strobe width is AXI_DWIDTH/8
- SUB_BASE, {N_SUB x AXI_AWIDTH}: packed base addresses, subordinate i in slice i
- SUB_MASK, {N_SUB x AXI_AWIDTH}: packed decode masks; hit_i = ((addr & SUB_MASK[i]) == SUB_BASE[i])
- AXI_ACLK  in  1  single clock, rising edge
- AXI_ARESETN  in  1  asynchronous, active-low reset
- HOST_AXI_{AWADDR,AWVALID,AWREADY,WDATA,WSTRB,WVALID,WREADY,BRESP,BVALID,BREADY}  manager-facing write channels, standard AXI4-Lite directions and widths
- HOST_AXI_{ARADDR,ARVALID,ARREADY,RDATA,RRESP,RVALID,RREADY}  manager-facing read channels
- SUB_AXI_*  same signal set toward subordinates, each packed N_SUB x width; slice i belongs to subordinate i

## Operation
- Decode: lowest index wins when several subordinates hit. No hit selects the internal error responder.
- Write FSM states: W_IDLE, W_FWD, W_RESP, W_ERR.
  - W_IDLE: AWREADY and WREADY are high independently. Each channel is captured into a register when it handshakes, then its ready drops. When both are captured, decode and go to W_FWD on a hit or W_ERR on a miss.
  - W_FWD: drive SUB_AWVALID[sel] and SUB_WVALID[sel] from the registers. Each drops after its own handshake. Once both have completed, assert SUB_BREADY[sel]; on SUB_BVALID[sel], capture BRESP and go to W_RESP.
  - W_RESP: HOST_BVALID=1 with the captured BRESP. On BREADY, go to W_IDLE.
  - W_ERR: HOST_BVALID=1, BRESP=2'b11. On BREADY, go to W_IDLE.
- Read FSM states: R_IDLE, R_FWD, R_WAIT, R_RESP, R_ERR.
  - R_IDLE: ARREADY=1. On handshake, capture ARADDR and decode.
  - R_FWD: SUB_ARVALID[sel] held until SUB_ARREADY[sel], then go to R_WAIT.
  - R_WAIT: SUB_RREADY[sel]=1. On SUB_RVALID[sel], capture RDATA and RRESP, then go to R_RESP.
  - R_RESP: HOST_RVALID=1, held stable until RREADY, then go to R_IDLE.
  - R_ERR: HOST_RVALID=1, RDATA=0, RRESP=2'b11. On RREADY, go to R_IDLE.
- Non-selected subordinate slices keep every valid and ready output at 0.
- A read and a write to the same subordinate may be in flight simultaneously; ordering between them is not guaranteed.

## Timing
- Reset values:
  - all SUB_*VALID, SUB_BREADY, SUB_RREADY, HOST_BVALID and HOST_RVALID are 0
  - HOST_AWREADY, HOST_WREADY and HOST_ARREADY are 1 one cycle after reset deasserts; they are 0 while reset is asserted
  - data and response outputs are 0
- Read latency: host AR handshake at T → SUB_ARVALID at T+1. A zero-wait subordinate gives SUB_RVALID at T+2 → HOST_RVALID at T+3.
- Write latency: AW and W handshake together at T → SUB_AWVALID and SUB_WVALID at T+1. Subordinate BVALID at T+2 → HOST_BVALID at T+3.
- AW before W, or W before AW: the transaction is forwarded the cycle after the later of the two handshakes.
- DECERR: the response valid is asserted the cycle after the address (and, for writes, the data) is captured.
- Once asserted, a valid stays high, with payload stable, until its handshake.
- Reset asserted mid-transaction: both FSMs return to idle and all valids drop immediately. In-flight transactions are lost; the subordinates are reset by the same signal.

## Structure
- Shared package axil_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - write and read FSM state typedefs
- One sub-module, axil_addr_decode: combinational; inputs address, SUB_BASE and SUB_MASK; outputs a one-hot select vector and a hit flag. It is instantiated twice, once for AW and once for AR.

## Test plan
- N_SUB=3 with bases 0x0000 (mask 0xC000), 0x4000 (mask 0xC000) and 0x8000 (mask 0xF000).
  - Read 0x4010 → only SUB1 ARVALID with ARADDR 0x4010; SUB1 returns 0xDEADBEEF → host RDATA=0xDEADBEEF, RRESP=0 at T+3.
- Write 0x0004, WDATA 0x12345678, WSTRB 4'b0011, with W presented 2 cycles before AW → SUB0 receives both values unchanged; BRESP=0 reaches the host.
- Read 0xF000 (unmapped) → no SUB valid ever asserts; HOST RVALID at T+1 with RDATA=0, RRESP=2'b11. Write to the same address → BRESP=2'b11.
- Host holds RREADY and BREADY low for 5 cycles → RVALID, BVALID and their payloads remain stable; no new AR or AW is accepted meanwhile.
- Read of SUB2 concurrent with a write to SUB0; SUB2 returns SLVERR → both complete independently and the read returns RRESP=2'b10.
- Assert AXI_ARESETN low while in R_WAIT and W_FWD → all valids drop to 0 at once; after release the ready signals return to 1 and a fresh read completes correctly.
